// File: rtl/juego_pkg.sv
// Shared minesweeper types and constants: board size, FSM states,
// board matrix type and the 8-neighbour offset table.
// Latency: n/a (package). Backpressure: n/a.
package juego_pkg;

    localparam int N = 8;
    localparam int W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SCAN,
        DONE
    } estado_t;

    // Row-major board: m[fila][col]
    typedef logic [N-1:0] matriz_t [N];

    // Neighbour offsets in scan order: NW, N, NE, W, E, SW, S, SE
    localparam logic signed [1:0] OFF_F [8] = '{-2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};
    localparam logic signed [1:0] OFF_C [8] = '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};

    // Neighbour coordinate in W+1-bit signed arithmetic. A set sign bit
    // means off-board: -1 is negative, and N (=8) overflows to -8.
    function automatic logic signed [W:0] vecino(input logic [W-1:0] base,
                                                 input logic signed [1:0] off);
        logic signed [W:0] b;
        logic signed [W:0] o;
        b = $signed({1'b0, base});
        o = off;
        return b + o;
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// Registered 0->1 edge detector for an active-low button (fires on release).
// Latency: combinational pulse in the cycle the input is first seen high after a low.
// Backpressure: none; history tracks the input every cycle.
// Ports: clk, rst (sync, active-high), d (raw level), flanco (one-cycle rising-edge pulse).
module detector_flanco (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic flanco
);

    logic d_q;

    // History resets to 1 so a button held high through reset is not an edge
    always_ff @(posedge clk) begin
        if (rst) d_q <= 1'b1;
        else     d_q <= d;
    end

    assign flanco = !rst && !d_q && d;

endmodule

// File: rtl/revelar_casilla.sv
// Reveals one board cell: bomb check, then 8-neighbour bomb count, then mask update.
// Latency: listo at T+10 (safe cell) or T+2 (bomb / already revealed) after the release edge.
// Backpressure: presses while ocupado, or after a bomb, are dropped (never queued).
// Ports: clk, rst; fila/col target; button_revelar (active low); matriz_bombas in;
//        matriz_revelada, conteo, bomba_encontrada, ya_revelada, revelados, ocupado, listo out.
module revelar_casilla
    import juego_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] fila,
    input  logic [W-1:0] col,
    input  logic         button_revelar,
    input  matriz_t      matriz_bombas,
    output matriz_t      matriz_revelada,
    output logic [3:0]   conteo,
    output logic         bomba_encontrada,
    output logic         ya_revelada,
    output logic [6:0]   revelados,
    output logic         ocupado,
    output logic         listo
);

    estado_t           state;
    estado_t           state_d;
    logic [W-1:0]      f_r;
    logic [W-1:0]      c_r;
    logic [3:0]        acc;
    logic [2:0]        idx;
    logic              seguro;     // remembers that DONE must commit a safe reveal
    logic              evento;
    logic signed [W:0] nf;
    logic signed [W:0] nc;
    logic              bomba_vecino;
    logic              celda_bomba;
    logic              celda_revelada;

    detector_flanco u_flanco (
        .clk    (clk),
        .rst    (rst),
        .d      (button_revelar),
        .flanco (evento)
    );

    assign nf             = vecino(f_r, OFF_F[idx]);
    assign nc             = vecino(c_r, OFF_C[idx]);
    assign bomba_vecino   = !nf[W] && !nc[W] && matriz_bombas[nf[W-1:0]][nc[W-1:0]];
    assign celda_bomba    = matriz_bombas[f_r][c_r];
    assign celda_revelada = matriz_revelada[f_r][c_r];

    assign ocupado = (state != IDLE);
    assign listo   = (state == DONE);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (evento && !bomba_encontrada) state_d = CHECK;
            CHECK:   state_d = (celda_revelada || celda_bomba) ? DONE : SCAN;
            SCAN:    if (idx == 3'd7) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            f_r              <= '0;
            c_r              <= '0;
            acc              <= '0;
            idx              <= '0;
            seguro           <= 1'b0;
            matriz_revelada  <= '{default: '0};
            conteo           <= '0;
            bomba_encontrada <= 1'b0;
            ya_revelada      <= 1'b0;
            revelados        <= '0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (evento && !bomba_encontrada) begin
                        f_r         <= fila;
                        c_r         <= col;
                        ya_revelada <= 1'b0;
                    end
                end
                CHECK: begin
                    seguro <= 1'b0;
                    if (celda_revelada) begin
                        ya_revelada <= 1'b1;
                    end else if (celda_bomba) begin
                        bomba_encontrada     <= 1'b1;
                        conteo               <= '0;
                        matriz_revelada[f_r][c_r] <= 1'b1;
                    end else begin
                        acc    <= '0;
                        idx    <= '0;
                        seguro <= 1'b1;
                    end
                end
                SCAN: begin
                    acc <= acc + {3'b000, bomba_vecino};
                    idx <= idx + 3'd1;
                end
                DONE: begin
                    if (seguro) begin
                        conteo                    <= acc;
                        matriz_revelada[f_r][c_r] <= 1'b1;
                        if (revelados != 7'd64) revelados <= revelados + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
